// File: rtl/ucie_ctl_tx_buffer.sv
// Transmit elastic buffer between FDI (protocol layer) and RDI (physical adapter).
// Show-ahead FIFO: head word is presented combinationally, one cycle after push.
module ucie_ctl_tx_buffer #(
  parameter int NBYTES = 32,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_buffer_en,
  input  logic              i_flush,
  input  logic [NBYTES-1:0] i_fdi_lp_data,
  input  logic              i_fdi_lp_valid,
  input  logic              i_fdi_lp_irdy,
  output logic              o_fdi_pl_trdy,
  output logic [NBYTES-1:0] o_rdi_lp_data,
  output logic              o_rdi_lp_valid,
  output logic              o_rdi_lp_irdy,
  input  logic              i_rdi_pl_trdy,
  output logic              o_overflow_detected,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [NBYTES-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              full;
  logic              push;
  logic              pop;

  // Handshake decode and next-state for pointers, occupancy and sticky overflow
  always_comb begin
    full           = (count_q == CNT_W'(DEPTH));
    o_fdi_pl_trdy  = i_buffer_en & ~i_flush & ~full;
    o_rdi_lp_valid = i_buffer_en & (count_q != '0);
    o_rdi_lp_irdy  = o_rdi_lp_valid;
    o_rdi_lp_data  = mem_q[rd_ptr_q];
    o_count        = count_q;
    o_empty        = (count_q == '0);
    o_overflow_detected = ovf_q;

    push = o_fdi_pl_trdy & i_fdi_lp_valid & i_fdi_lp_irdy;
    pop  = o_rdi_lp_valid & i_rdi_pl_trdy & ~i_flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (i_buffer_en & i_fdi_lp_valid & i_fdi_lp_irdy & full & ~i_flush);

    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; contents are intentionally not reset
  always_ff @(posedge i_clk) begin
    if (!i_rst && push) mem_q[wr_ptr_q] <= i_fdi_lp_data;
  end

endmodule

// File: tb/tb_ucie_ctl_tx_buffer.sv
// Bench for ucie_ctl_tx_buffer: queue-based reference model checked every cycle,
// directed sequences from the test plan with literal expectations, then random traffic.
module tb_ucie_ctl_tx_buffer;

  localparam int NBYTES = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst, en, flush, fv, firdy, ptrdy;
  logic [NBYTES-1:0] fdata;
  logic              ftrdy, rvalid, rirdy, ovf, empty;
  logic [NBYTES-1:0] rdata;
  logic [CNT_W-1:0]  count;

  int checks = 0;
  int errors = 0;

  logic [NBYTES-1:0] mq[$];
  logic              movf;
  bit                model_known = 1'b0;

  always #5 clk = ~clk;

  ucie_ctl_tx_buffer #(.NBYTES(NBYTES), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_buffer_en(en), .i_flush(flush),
    .i_fdi_lp_data(fdata), .i_fdi_lp_valid(fv), .i_fdi_lp_irdy(firdy),
    .o_fdi_pl_trdy(ftrdy), .o_rdi_lp_data(rdata), .o_rdi_lp_valid(rvalid),
    .o_rdi_lp_irdy(rirdy), .i_rdi_pl_trdy(ptrdy),
    .o_overflow_detected(ovf), .o_count(count), .o_empty(empty)
  );

  task automatic chk(input string name, input logic [NBYTES-1:0] act, input logic [NBYTES-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock: drive inputs, compare outputs to the model mid-cycle, advance model at the edge
  task automatic step(input logic r, input logic e, input logic f, input logic v,
                      input logic ir, input logic [NBYTES-1:0] d, input logic pt);
    bit e_trdy, e_valid, do_push, do_pop, do_ovf;
    rst = r; en = e; flush = f; fv = v; firdy = ir; fdata = d; ptrdy = pt;
    @(negedge clk);
    e_trdy  = e && !f && (mq.size() < DEPTH);
    e_valid = e && (mq.size() != 0);
    if (model_known) begin
      chk("fdi_trdy",  {31'b0, ftrdy},  {31'b0, e_trdy});
      chk("rdi_valid", {31'b0, rvalid}, {31'b0, e_valid});
      chk("rdi_irdy",  {31'b0, rirdy},  {31'b0, e_valid});
      chk("count",     {{(NBYTES-CNT_W){1'b0}}, count}, NBYTES'(mq.size()));
      chk("empty",     {31'b0, empty},  {31'b0, mq.size() == 0});
      chk("overflow",  {31'b0, ovf},    {31'b0, movf});
      if (e_valid) chk("rdi_data", rdata, mq[0]);
    end
    do_push = e_trdy && v && ir;
    do_pop  = e_valid && pt && !f;
    do_ovf  = e && v && ir && !f && (mq.size() == DEPTH);
    @(posedge clk);
    #1;
    if (r) begin
      mq.delete();
      movf = 1'b0;
      model_known = 1'b1;
    end else if (f) begin
      mq.delete();
    end else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(d);
      if (do_ovf)  movf = 1'b1;
    end
  endtask

  task automatic push_w(input logic [NBYTES-1:0] d, input logic pt);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, d, pt);
  endtask

  task automatic idle(input logic pt);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, pt);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; fv = 1'b0; firdy = 1'b0; fdata = '0; ptrdy = 1'b0;
    movf = 1'b0;

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEAD, 1'b1);
    chk("rst_count", NBYTES'(count), 32'd0);
    chk("rst_empty", {31'b0, empty}, 32'd1);

    // Stream three words straight through
    push_w(32'hA1, 1'b1);
    chk("stream_first", rdata, 32'hA1);
    push_w(32'hA2, 1'b1);
    chk("stream_second", rdata, 32'hA2);
    push_w(32'hA3, 1'b1);
    idle(1'b1);
    chk("stream_drained", NBYTES'(count), 32'd0);
    idle(1'b1);

    // Fill past full with backpressure
    for (int unsigned i = 0; i < 5; i++) begin
      push_w(32'h10 + i, 1'b0);
      if (i == 3) begin
        chk("full_count", NBYTES'(count), 32'd4);
        chk("full_trdy", {31'b0, ftrdy}, 32'd0);
      end
    end
    chk("ovf_set", {31'b0, ovf}, 32'd1);
    for (int unsigned i = 0; i < 4; i++) begin
      chk("drain_data", rdata, 32'h10 + i);
      idle(1'b1);
    end
    chk("drain_empty", {31'b0, empty}, 32'd1);
    chk("ovf_sticky", {31'b0, ovf}, 32'd1);

    // Steady push/pop at occupancy 2, wrapping pointers
    push_w(32'h20, 1'b0);
    push_w(32'h21, 1'b0);
    for (int unsigned i = 0; i < 6; i++) push_w(32'h30 + i, 1'b1);
    chk("steady_count", NBYTES'(count), 32'd2);
    chk("steady_head", rdata, 32'h34);

    // Hold under backpressure, then single pop
    for (int unsigned i = 0; i < 3; i++) idle(1'b0);
    chk("hold_data", rdata, 32'h34);
    idle(1'b1);
    chk("hold_pop_count", NBYTES'(count), 32'd1);

    // Flush while pushing
    push_w(32'h40, 1'b0);
    push_w(32'h41, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h42, 1'b1);
    chk("flush_count", NBYTES'(count), 32'd0);
    chk("flush_ovf", {31'b0, ovf}, 32'd1);
    idle(1'b0);

    // Disable freezes, re-enable resumes, reset mid-drain
    push_w(32'h50, 1'b0);
    push_w(32'h51, 1'b0);
    for (int unsigned i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h5F, 1'b1);
    chk("dis_valid", {31'b0, rvalid}, 32'd0);
    chk("dis_count", NBYTES'(count), 32'd2);
    chk("dis_trdy", {31'b0, ftrdy}, 32'd0);
    chk("reen_head", rdata, 32'h50);
    idle(1'b1);
    chk("reen_next", rdata, 32'h51);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("rst_mid_count", NBYTES'(count), 32'd0);
    chk("rst_mid_ovf", {31'b0, ovf}, 32'd0);

    // Random traffic against the model
    for (int unsigned i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 24) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0,
           $urandom,
           $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ucie_ctl_tx_buffer.md
Name: ucie_ctl_tx_buffer

Overview:
Transmit-direction elastic buffer of the UCIe controller, between the FDI (protocol-layer side) and the RDI (physical-adapter side). Accepts flits from the FDI with a valid/irdy/trdy handshake and presents them in order on the RDI with backpressure from pl_trdy. It also reports overflow attempts and occupancy. It is the transmit counterpart of the controller's RX buffer.

Parameters:
NBYTES, 32, data bus width in bits on both FDI and RDI sides
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst  input  1  synchronous, active-high reset
i_buffer_en  input  1  block enable; low freezes both push and pop
i_flush  input  1  synchronous flush of FIFO contents
i_fdi_lp_data  input  NBYTES  flit data from protocol layer
i_fdi_lp_valid  input  1  FDI data valid
i_fdi_lp_irdy  input  1  FDI initiator ready
o_fdi_pl_trdy  output  1  buffer can accept this cycle
o_rdi_lp_data  output  NBYTES  data towards the physical adapter
o_rdi_lp_valid  output  1  RDI data valid
o_rdi_lp_irdy  output  1  RDI initiator ready; always equal to o_rdi_lp_valid
i_rdi_pl_trdy  input  1  physical adapter accepts the current word
o_overflow_detected  output  1  sticky: push attempted while full
o_count  output  CNT_W  current occupancy
o_empty  output  1  count == 0

Behaviour:
- Reset (i_rst=1 at posedge): wr_ptr=rd_ptr=0, count=0, o_overflow_detected=0. Combinational outputs then read: o_rdi_lp_valid=0, o_rdi_lp_irdy=0, o_empty=1, o_count=0, o_fdi_pl_trdy=i_buffer_en. Memory contents are not reset. o_rdi_lp_data is don't-care while valid=0. Reset wins over every other input.
- o_fdi_pl_trdy = i_buffer_en & ~i_flush & (count < DEPTH). Combinational, with no dependency on i_fdi_lp_valid.
- push = o_fdi_pl_trdy & i_fdi_lp_valid & i_fdi_lp_irdy. On push: mem[wr_ptr] <= data, wr_ptr increments and wraps modulo DEPTH.
- o_rdi_lp_valid = i_buffer_en & (count != 0). The FIFO is show-ahead: o_rdi_lp_data = mem[rd_ptr] combinationally.
- pop = o_rdi_lp_valid & i_rdi_pl_trdy & ~i_flush. On pop: rd_ptr increments and wraps modulo DEPTH.
- Data and valid hold stable while valid=1 and trdy=0. A word is never dropped or duplicated.
- Latency: a word pushed at edge N appears on the RDI in the cycle after edge N (one cycle). There is no bypass when empty.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither. Push and pop in the same cycle is legal at any occupancy 1..DEPTH-1.
- Full (count == DEPTH): trdy=0, so no push. A pop in that cycle frees a slot, and trdy rises on the next cycle (no same-cycle full bypass).
- Overflow: i_buffer_en & i_fdi_lp_valid & i_fdi_lp_irdy & (count == DEPTH) & ~i_flush sets o_overflow_detected at the next edge. It stays set until reset, and data is not written.
- i_flush=1: ptrs and count clear to 0 at the edge, and push and pop are suppressed. It does not clear o_overflow_detected.
- i_buffer_en=0: no push, no pop, no overflow detection. Contents, pointers and count are retained, and valid drops to 0. When enable returns, draining resumes from the same rd_ptr.
- Reset mid-transfer discards all stored words.

Test Plan:
- Reset, then en=1, push 0xA1,0xA2,0xA3 on consecutive cycles with pl_trdy=1 -> RDI shows 0xA1,0xA2,0xA3 one cycle after each push, valid=irdy=1 for exactly 3 cycles, count returns to 0, empty=1.
- pl_trdy=0, push 5 words 0x10..0x14 (DEPTH=4) -> count=4, fdi trdy=0 after the 4th, overflow=1 on the 5th. Release trdy -> out 0x10..0x13 in order, 0x14 never appears, overflow stays 1.
- Fill to 2, then push and pop together for 6 cycles -> count stays 2, pointers wrap past 3->0, output order matches input order exactly.
- Hold pl_trdy=0 with valid=1 for 3 cycles -> o_rdi_lp_data is constant and count is unchanged. Then 1 cycle of trdy=1 -> count decrements by 1.
- Fill 3 words, pulse i_flush while pushing -> count=0, empty=1, pushed word discarded, overflow unchanged.
- Fill 2 words, drop en for 4 cycles -> valid=0, trdy=0, count=2. Re-enable -> same 2 words drain in order. Assert i_rst mid-drain -> count=0, valid=0 at the next cycle.
